cfu_initiator: RTL and testbench



---
 rtl/cfu_initiator.sv | 137 +++++++++++++
 tb/tb_cfu_initiator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cfu_initiator: tags core operations onto the CFU request channel and       |
// | retires out-of-order CFU responses back to the core in issue order.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cfu_initiator #(
  parameter int CFU_INTERFACE_ID_W = 16,
  parameter int CFU_FUNCTION_ID_W  = 16,
  parameter int CFU_REORDER_ID_W   = 8,
  parameter int CFU_REQ_RESP_ID_W  = 6,
  parameter int CFU_REQ_DATA_W     = 32,
  parameter int CFU_RESP_DATA_W    = CFU_REQ_DATA_W,
  parameter int CFU_ERROR_ID_W     = CFU_RESP_DATA_W,
  parameter int DEPTH              = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clock_en,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [CFU_INTERFACE_ID_W-1:0] cmd_interface_id,
  input  logic [CFU_FUNCTION_ID_W-1:0]  cmd_function_id,
  input  logic [CFU_REORDER_ID_W-1:0]   cmd_reorder_id,
  input  logic [2*CFU_REQ_DATA_W-1:0]   cmd_data,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [CFU_INTERFACE_ID_W-1:0] req_interface_id,
  output logic [CFU_FUNCTION_ID_W-1:0]  req_function_id,
  output logic [CFU_REORDER_ID_W-1:0]   req_reorder_id,
  output logic [CFU_REQ_RESP_ID_W-1:0]  req_id,
  output logic [2*CFU_REQ_DATA_W-1:0]   req_data,
  input  logic                          resp_valid,
  output logic                          resp_ready,
  input  logic [CFU_REQ_RESP_ID_W-1:0]  resp_id,
  input  logic [CFU_RESP_DATA_W-1:0]    resp_data,
  input  logic                          resp_ok,
  input  logic [CFU_ERROR_ID_W-1:0]     resp_error_id,
  output logic                          ret_valid,
  input  logic                          ret_ready,
  output logic [CFU_RESP_DATA_W-1:0]    ret_data,
  output logic                          ret_ok,
  output logic [CFU_ERROR_ID_W-1:0]     ret_error_id,
  output logic [$clog2(DEPTH):0]        outstanding,
  output logic                          spurious
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
  logic [PW:0]                count_q, count_d;
  logic [DEPTH-1:0]           busy_q, done_q, ok_q;
  logic [CFU_RESP_DATA_W-1:0] data_q [DEPTH];
  logic [CFU_ERROR_ID_W-1:0]  err_q  [DEPTH];
  logic                       spurious_q;

  logic          w_full, w_issue, w_resp, w_hit, w_retire;
  logic [PW-1:0] w_idx;

  assign w_full    = (count_q == (PW+1)'(DEPTH));
  assign req_valid = cmd_valid && !w_full && clock_en && reset;
  assign cmd_ready = req_ready && !w_full && clock_en && reset;
  assign w_issue   = cmd_valid && cmd_ready;

  assign req_interface_id = cmd_interface_id;
  assign req_function_id  = cmd_function_id;
  assign req_reorder_id   = cmd_reorder_id;
  assign req_data         = cmd_data;
  assign req_id           = CFU_REQ_RESP_ID_W'(tail_q);

  // Slots are reserved at issue, so responses never need back-pressure.
  assign resp_ready = clock_en && reset;
  assign w_resp     = resp_valid && resp_ready;
  assign w_idx      = resp_id[PW-1:0];
  assign w_hit      = ((resp_id >> PW) == '0) && busy_q[w_idx] && !done_q[w_idx];

  assign ret_valid    = busy_q[head_q] && done_q[head_q] && clock_en;
  assign ret_data     = data_q[head_q];
  assign ret_ok       = ok_q[head_q];
  assign ret_error_id = err_q[head_q];
  assign w_retire     = ret_valid && ret_ready;

  assign outstanding = count_q;
  assign spurious    = spurious_q;

  always_comb begin
    head_d  = w_retire ? head_q + 1'b1 : head_q;
    tail_d  = w_issue  ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({w_issue, w_retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      done_q     <= '0;
      ok_q       <= '0;
      spurious_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= '0;
      end
    end else if (clock_en) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Issue, capture and retire touch disjoint entries in any one cycle.
      if (w_issue) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
      end
      if (w_resp) begin
        if (w_hit) begin
          done_q[w_idx] <= 1'b1;
          ok_q[w_idx]   <= resp_ok;
          data_q[w_idx] <= resp_data;
          err_q[w_idx]  <= resp_error_id;
        end else begin
          spurious_q <= 1'b1;
        end
      end
      if (w_retire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfu_initiator.sv
`default_nettype none
// Bench for cfu_initiator: directed stimulus, queue-based scoreboard on the retire port.
module tb_cfu_initiator;

  logic        clock, reset, clock_en;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_interface_id, cmd_function_id;
  logic [7:0]  cmd_reorder_id;
  logic [63:0] cmd_data;
  logic        req_valid, req_ready;
  logic [15:0] req_interface_id, req_function_id;
  logic [7:0]  req_reorder_id;
  logic [5:0]  req_id;
  logic [63:0] req_data;
  logic        resp_valid, resp_ready, resp_ok;
  logic [5:0]  resp_id;
  logic [31:0] resp_data, resp_error_id;
  logic        ret_valid, ret_ready, ret_ok;
  logic [31:0] ret_data, ret_error_id;
  logic [2:0]  outstanding;
  logic        spurious;

  typedef struct {
    logic [31:0] d;
    logic        ok;
    logic [31:0] e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   retires = 0;

  cfu_initiator dut (
    .clock(clock), .reset(reset), .clock_en(clock_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_interface_id(cmd_interface_id), .cmd_function_id(cmd_function_id),
    .cmd_reorder_id(cmd_reorder_id), .cmd_data(cmd_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_interface_id(req_interface_id), .req_function_id(req_function_id),
    .req_reorder_id(req_reorder_id), .req_id(req_id), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_ok(resp_ok), .resp_error_id(resp_error_id),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_data(ret_data),
    .ret_ok(ret_ok), .ret_error_id(ret_error_id),
    .outstanding(outstanding), .spurious(spurious)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Retire monitor: handshake completes at the next rising edge.
  always @(negedge clock) begin
    if (reset && ret_valid && ret_ready) begin
      retires++;
      if (sb.size() == 0) begin
        chk("ret_unexpected", 64'(ret_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ret_data", 64'(ret_data), 64'(e.d));
        chk("ret_ok", 64'(ret_ok), 64'(e.ok));
        chk("ret_error_id", 64'(ret_error_id), 64'(e.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic issue(input logic [15:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] exp_id, input logic [31:0] rd,
                       input logic rok, input logic [31:0] rerr);
    exp_t e;
    cmd_valid        = 1'b1;
    cmd_function_id  = fn;
    cmd_interface_id = 16'h0001;
    cmd_reorder_id   = 8'(exp_id);
    cmd_data         = {b, a};
    #2;
    chk("req_valid", 64'(req_valid), 64'd1);
    chk("req_id", 64'(req_id), 64'(exp_id));
    chk("req_data", req_data, {b, a});
    e.d = rd; e.ok = rok; e.e = rerr;
    sb.push_back(e);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [5:0] id, input logic [31:0] d,
                         input logic ok, input logic [31:0] err);
    resp_valid = 1'b1; resp_id = id; resp_data = d; resp_ok = ok; resp_error_id = err;
    @(posedge clock);
    #1 resp_valid = 1'b0;
  endtask

  initial begin
    exp_t e2;
    reset = 1'b0; clock_en = 1'b1; cmd_valid = 1'b1; req_ready = 1'b1;
    cmd_interface_id = '0; cmd_function_id = '0; cmd_reorder_id = '0; cmd_data = '0;
    resp_valid = 1'b0; resp_id = '0; resp_data = '0; resp_ok = 1'b1; resp_error_id = '0;
    ret_ready = 1'b1;

    // Reset holds all handshakes low even with cmd offered.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_resp_ready", 64'(resp_ready), 64'd0);
    chk("rst_ret_valid", 64'(ret_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_spurious", 64'(spurious), 64'd0);
    cmd_valid = 1'b0;
    reset = 1'b1;
    #1 chk("idle_cmd_ready_hi", 64'(cmd_ready), 64'd1);
    req_ready = 1'b0;
    #1 chk("idle_cmd_ready_lo", 64'(cmd_ready), 64'd0);
    req_ready = 1'b1;
    idle(1);

    // In-order: 3*4=12, 5*6=30.
    issue(16'd0, 32'd3, 32'd4, 6'd0, 32'd12, 1'b1, 32'd0);
    issue(16'd0, 32'd5, 32'd6, 6'd1, 32'd30, 1'b1, 32'd0);
    chk("io_outstanding2", 64'(outstanding), 64'd2);
    idle(1);
    respond(6'd0, 32'd12, 1'b1, 32'd0);
    chk("io_ret_valid", 64'(ret_valid), 64'd1);
    respond(6'd1, 32'd30, 1'b1, 32'd0);
    idle(2);
    chk("io_outstanding0", 64'(outstanding), 64'd0);
    chk("io_retires", 64'(retires), 64'd2);

    // Out-of-order completion, fill to DEPTH.
    do_reset();
    for (int i = 0; i < 4; i++)
      issue(16'd1, 32'(i), 32'd0, 6'(i), 32'(100 + i), 1'b1, 32'd0);
    chk("ooo_full_count", 64'(outstanding), 64'd4);
    cmd_valid = 1'b1;
    #1;
    chk("ooo_full_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("ooo_full_req_valid", 64'(req_valid), 64'd0);
    cmd_valid = 1'b0;
    respond(6'd3, 32'd103, 1'b1, 32'd0);
    chk("ooo_wait3", 64'(ret_valid), 64'd0);
    respond(6'd1, 32'd101, 1'b1, 32'd0);
    chk("ooo_wait1", 64'(ret_valid), 64'd0);
    respond(6'd2, 32'd102, 1'b1, 32'd0);
    chk("ooo_wait2", 64'(ret_valid), 64'd0);
    respond(6'd0, 32'd100, 1'b1, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("ooo_drain_count", 64'(outstanding), 64'(4 - k));
      chk("ooo_drain_valid", 64'(ret_valid), 64'd1);
      idle(1);
    end
    chk("ooo_empty", 64'(outstanding), 64'd0);
    chk("ooo_ret_valid_lo", 64'(ret_valid), 64'd0);

    // Back-pressure on retire; pointers wrap from the previous test.
    ret_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(16'd2, 32'(i), 32'd1, 6'(i), 32'(200 + i), 1'b1, 32'd0);
    for (int i = 0; i < 4; i++)
      respond(6'(i), 32'(200 + i), 1'b1, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_ret_valid", 64'(ret_valid), 64'd1);
      chk("bp_ret_data", 64'(ret_data), 64'd200);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_count", 64'(outstanding), 64'd4);
      idle(1);
    end
    ret_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_count", 64'(outstanding), 64'(4 - k));
      idle(1);
    end
    chk("bp_empty", 64'(outstanding), 64'd0);
    issue(16'd2, 32'd9, 32'd9, 6'd0, 32'd300, 1'b1, 32'd0);
    respond(6'd0, 32'd300, 1'b1, 32'd0);
    idle(2);

    // Error passthrough, then a response for an idle tag.
    do_reset();
    issue(16'd3, 32'd1, 32'd2, 6'd0, 32'hDEAD, 1'b0, 32'h55);
    respond(6'd0, 32'hDEAD, 1'b0, 32'h55);
    chk("err_ret_ok", 64'(ret_ok), 64'd0);
    chk("err_ret_error_id", 64'(ret_error_id), 64'h55);
    idle(1);
    chk("err_no_spurious", 64'(spurious), 64'd0);
    respond(6'd2, 32'd7, 1'b1, 32'd0);
    chk("sp_set", 64'(spurious), 64'd1);
    chk("sp_count", 64'(outstanding), 64'd0);
    chk("sp_ret_valid", 64'(ret_valid), 64'd0);
    idle(3);
    chk("sp_sticky", 64'(spurious), 64'd1);

    // Out-of-range tag (upper bits set) aliasing a busy entry.
    do_reset();
    chk("sp_cleared", 64'(spurious), 64'd0);
    issue(16'd4, 32'd0, 32'd0, 6'd0, 32'h11, 1'b1, 32'd0);
    respond(6'd4, 32'h99, 1'b1, 32'd0);
    chk("range_spurious", 64'(spurious), 64'd1);
    chk("range_ret_valid", 64'(ret_valid), 64'd0);
    chk("range_count", 64'(outstanding), 64'd1);
    respond(6'd0, 32'h11, 1'b1, 32'd0);
    idle(2);
    chk("range_empty", 64'(outstanding), 64'd0);

    // Response to a tag issued in the same cycle.
    do_reset();
    resp_valid = 1'b1; resp_id = 6'd0; resp_data = 32'h22; resp_ok = 1'b1; resp_error_id = '0;
    issue(16'd5, 32'd0, 32'd0, 6'd0, 32'h23, 1'b1, 32'd0);
    resp_valid = 1'b0;
    chk("same_cyc_spurious", 64'(spurious), 64'd1);
    chk("same_cyc_ret_valid", 64'(ret_valid), 64'd0);
    respond(6'd0, 32'h23, 1'b1, 32'd0);
    idle(2);

    // clock_en gating with a pending response and command.
    do_reset();
    issue(16'd6, 32'd7, 32'd11, 6'd0, 32'd77, 1'b1, 32'd0);
    cmd_valid = 1'b1; cmd_function_id = 16'd6; cmd_data = {32'd8, 32'd11};
    resp_valid = 1'b1; resp_id = 6'd0; resp_data = 32'd77; resp_ok = 1'b1; resp_error_id = '0;
    clock_en = 1'b0;
    e2.d = 32'd88; e2.ok = 1'b1; e2.e = 32'd0;
    sb.push_back(e2);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ce_req_valid", 64'(req_valid), 64'd0);
      chk("ce_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("ce_resp_ready", 64'(resp_ready), 64'd0);
      chk("ce_ret_valid", 64'(ret_valid), 64'd0);
      chk("ce_count", 64'(outstanding), 64'd1);
      @(posedge clock);
      #1;
    end
    clock_en = 1'b1;
    #1;
    chk("ce_resume_req_valid", 64'(req_valid), 64'd1);
    chk("ce_resume_req_id", 64'(req_id), 64'd1);
    chk("ce_resume_resp_ready", 64'(resp_ready), 64'd1);
    @(posedge clock);
    #1 cmd_valid = 1'b0; resp_valid = 1'b0;
    chk("ce_after_count", 64'(outstanding), 64'd2);
    chk("ce_after_ret_valid", 64'(ret_valid), 64'd1);
    chk("ce_after_ret_data", 64'(ret_data), 64'd77);
    respond(6'd1, 32'd88, 1'b1, 32'd0);
    idle(3);
    chk("ce_empty", 64'(outstanding), 64'd0);

    idle(2);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
